div_clk_monitor: RTL and testbench

- Measures, on i_ref_clk, the divided clock produced by the system's clock divider (the receiving end of the divided-clock interface).
- Reports measured period and high time in ref-clock cycles and compares them against the programmed division ratio.
- Flags lock, mismatch and loss of clock, for use by the system controller or a test/debug register block.

---
 rtl/div_clk_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_div_clk_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Measures the divided clock on the reference clock domain. It reports the
// rise-to-rise period and the high time in ref cycles, checks both against
// the programmed ratio, and raises lock, mismatch and loss-of-clock flags.
// Ports:
//   i_ref_clk   reference clock (rising edge)
//   i_rst_n     asynchronous active-low reset
//   i_mon_en    monitor enable; low returns to IDLE and clears everything
//   i_div_clk   divided clock under test, sampled as data
//   i_exp_ratio expected division ratio (0/1 = divider bypass, no check)
//   i_err_clr   single-cycle clear of sticky mismatch/timeout flags
//   o_period    last measured period (saturating)
//   o_high      last measured high time (saturating)
//   o_valid     one-cycle pulse when o_period/o_high update
//   o_locked    LOCK_COUNT consecutive matching periods
//   o_mismatch  sticky: a measured period failed the check
//   o_timeout   sticky: no rising edge within 2^CNT_WIDTH-1 cycles
module div_clk_monitor #(
   parameter int unsigned RATIO_WIDTH = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 10,
   parameter int unsigned LOCK_COUNT  = 2
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_mon_en,
   input  logic                   i_div_clk,
   input  logic [RATIO_WIDTH-1:0] i_exp_ratio,
   input  logic                   i_err_clr,
   output logic [RATIO_WIDTH-1:0] o_period,
   output logic [RATIO_WIDTH-1:0] o_high,
   output logic                   o_valid,
   output logic                   o_locked,
   output logic                   o_mismatch,
   output logic                   o_timeout
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [3:0]           LOCK_CNT4 = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic [CNT_WIDTH-1:0]   r_wait_cnt, w_wait_nxt;
   logic [CNT_WIDTH-1:0]   r_per_cnt, w_per_nxt;
   logic [CNT_WIDTH-1:0]   r_high_cnt, w_high_nxt;
   logic [3:0]             r_match_cnt, w_match_nxt;
   logic [RATIO_WIDTH-1:0] r_exp_d;
   logic [RATIO_WIDTH-1:0] w_period_nxt, w_high_out_nxt;
   logic                   w_valid_nxt, w_locked_nxt, w_mismatch_nxt, w_timeout_nxt;
   logic                   w_mismatch_set, w_timeout_set;

   logic                   w_s, w_rise, w_exp_chg, w_check_en, w_high_ok, w_pass;
   logic [CNT_WIDTH-1:0]   w_exp_ext, w_half;
   logic [RATIO_WIDTH-1:0] w_per_sat, w_high_sat;

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_rise     = w_s & ~r_s_d;
   assign w_exp_chg  = (i_exp_ratio != r_exp_d);
   assign w_check_en = (i_exp_ratio >= RATIO_WIDTH'(2));
   assign w_exp_ext  = CNT_WIDTH'(i_exp_ratio);
   assign w_half     = CNT_WIDTH'(i_exp_ratio >> 1);

   // Odd ratios allow either rounding of the half period for the high time.
   assign w_high_ok  = i_exp_ratio[0] ? ((r_high_cnt == w_half) || (r_high_cnt == w_half + CNT_ONE))
                                      : (r_high_cnt == w_half);
   assign w_pass     = (r_per_cnt == w_exp_ext) && w_high_ok;

   // Counts wider than the output saturate to all ones.
   assign w_per_sat  = (|r_per_cnt[CNT_WIDTH-1:RATIO_WIDTH])  ? '1 : r_per_cnt[RATIO_WIDTH-1:0];
   assign w_high_sat = (|r_high_cnt[CNT_WIDTH-1:RATIO_WIDTH]) ? '1 : r_high_cnt[RATIO_WIDTH-1:0];

   // Divided-clock synchronizer plus one delay stage for edge detection.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_div_clk};
         r_s_d  <= w_s;
      end
   end

   // State register.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state, counter and flag logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_nxt     = r_wait_cnt;
      w_per_nxt      = r_per_cnt;
      w_high_nxt     = r_high_cnt;
      w_match_nxt    = r_match_cnt;
      w_period_nxt   = o_period;
      w_high_out_nxt = o_high;
      w_valid_nxt    = 1'b0;
      w_mismatch_set = 1'b0;
      w_timeout_set  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_mon_en) w_state_nxt = S_ARM;
         end
         S_ARM: begin
            if (w_rise) begin
               w_wait_nxt  = '0;
               w_per_nxt   = CNT_ONE;
               w_high_nxt  = CNT_ONE;
               w_state_nxt = S_MEASURE;
            end else if (r_wait_cnt == CNT_MAX) begin
               w_timeout_set = 1'b1;
               w_wait_nxt    = '0;
               w_match_nxt   = '0;
            end else begin
               w_wait_nxt = r_wait_cnt + CNT_ONE;
            end
         end
         S_MEASURE: begin
            // A rise in the timeout cycle is treated as a normal capture.
            if (w_rise) begin
               w_period_nxt   = w_per_sat;
               w_high_out_nxt = w_high_sat;
               w_valid_nxt    = 1'b1;
               w_per_nxt      = CNT_ONE;
               w_high_nxt     = CNT_ONE;
               if (!w_check_en) begin
                  w_match_nxt = '0;
               end else if (w_pass) begin
                  w_match_nxt = (r_match_cnt >= LOCK_CNT4) ? LOCK_CNT4 : r_match_cnt + 4'd1;
               end else begin
                  w_match_nxt    = '0;
                  w_mismatch_set = 1'b1;
               end
            end else if (r_per_cnt == CNT_MAX) begin
               w_timeout_set = 1'b1;
               w_per_nxt     = '0;
               w_high_nxt    = '0;
               w_wait_nxt    = '0;
               w_match_nxt   = '0;
               w_state_nxt   = S_ARM;
            end else begin
               w_per_nxt  = r_per_cnt + CNT_ONE;
               w_high_nxt = r_high_cnt + CNT_WIDTH'(w_s);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // A new expected ratio restarts lock acquisition without flagging an error.
      if (w_exp_chg) w_match_nxt = '0;

      w_mismatch_nxt = w_mismatch_set | (o_mismatch & ~i_err_clr);
      w_timeout_nxt  = w_timeout_set  | (o_timeout  & ~i_err_clr);
      w_locked_nxt   = w_check_en && (w_match_nxt == LOCK_CNT4);

      // Disable discards any partial measurement and clears all results.
      if (!i_mon_en) begin
         w_state_nxt    = S_IDLE;
         w_wait_nxt     = '0;
         w_per_nxt      = '0;
         w_high_nxt     = '0;
         w_match_nxt    = '0;
         w_period_nxt   = '0;
         w_high_out_nxt = '0;
         w_valid_nxt    = 1'b0;
         w_locked_nxt   = 1'b0;
         w_mismatch_nxt = 1'b0;
         w_timeout_nxt  = 1'b0;
      end
   end

   // Counter and output registers.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait_cnt  <= '0;
         r_per_cnt   <= '0;
         r_high_cnt  <= '0;
         r_match_cnt <= '0;
         r_exp_d     <= '0;
         o_period    <= '0;
         o_high      <= '0;
         o_valid     <= 1'b0;
         o_locked    <= 1'b0;
         o_mismatch  <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         r_wait_cnt  <= w_wait_nxt;
         r_per_cnt   <= w_per_nxt;
         r_high_cnt  <= w_high_nxt;
         r_match_cnt <= w_match_nxt;
         r_exp_d     <= i_exp_ratio;
         o_period    <= w_period_nxt;
         o_high      <= w_high_out_nxt;
         o_valid     <= w_valid_nxt;
         o_locked    <= w_locked_nxt;
         o_mismatch  <= w_mismatch_nxt;
         o_timeout   <= w_timeout_nxt;
      end
   end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor
// Drives a behavioural clock divider into div_clk_monitor. Each completed
// divider period (except the first after a restart) is queued as an expected
// capture and compared when the DUT pulses o_valid. Flag behaviour is
// checked at fixed points of each scenario.
module tb_div_clk_monitor;

   logic       i_ref_clk;
   logic       i_rst_n;
   logic       i_mon_en;
   logic       i_div_clk;
   logic [7:0] i_exp_ratio;
   logic       i_err_clr;
   logic [7:0] o_period;
   logic [7:0] o_high;
   logic       o_valid;
   logic       o_locked;
   logic       o_mismatch;
   logic       o_timeout;

   div_clk_monitor u_dut (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_mon_en    (i_mon_en),
      .i_div_clk   (i_div_clk),
      .i_exp_ratio (i_exp_ratio),
      .i_err_clr   (i_err_clr),
      .o_period    (o_period),
      .o_high      (o_high),
      .o_valid     (o_valid),
      .o_locked    (o_locked),
      .o_mismatch  (o_mismatch),
      .o_timeout   (o_timeout)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] sb_q[$];

   // Divider model configuration; new settings take effect at a period boundary.
   bit div_en    = 1'b0;
   int cfg_per   = 4;
   bit cfg_alt   = 1'b0;
   int cur_per   = 4;
   int cur_hi    = 2;
   int ph        = 0;
   bit alt_phase = 1'b0;
   bit have_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      i_ref_clk = 1'b0;
      forever #5 i_ref_clk = ~i_ref_clk;
   end

   // Behavioural divider; queues the finished period when the next one starts.
   initial begin
      i_div_clk = 1'b0;
      forever begin
         @(negedge i_ref_clk);
         if (!div_en) begin
            i_div_clk = 1'b0;
            ph        = 0;
            have_prev = 1'b0;
            alt_phase = 1'b0;
         end else begin
            if (ph == 0) begin
               if (have_prev) sb_q.push_back({8'(cur_per), 8'(cur_hi)});
               have_prev = 1'b1;
               cur_per   = cfg_per;
               cur_hi    = (cfg_alt && alt_phase) ? cfg_per / 2 : (cfg_per + 1) / 2;
               alt_phase = !alt_phase;
            end
            i_div_clk = (ph < cur_hi);
            ph        = (ph + 1 == cur_per) ? 0 : ph + 1;
         end
      end
   end

   // Scoreboard consumer.
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge i_ref_clk);
         #1;
         if (o_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("period", 32'(o_period), 32'(e[15:8]));
               chk("high", 32'(o_high), 32'(e[7:0]));
            end
         end
      end
   end

   // Returns just after the n-th o_valid edge; bounded per pulse.
   task automatic wait_valid(input int n);
      int seen;
      int budget;
      seen   = 0;
      budget = 0;
      while (seen < n && budget < 300 * n) begin
         @(posedge i_ref_clk);
         #1;
         budget++;
         if (o_valid) seen++;
      end
      if (seen < n) chk("wait_valid_timeout", 32'(seen), 32'(n));
   endtask

   task automatic start_run(input int per, input bit alt, input logic [7:0] exp, input bit en);
      i_mon_en = 1'b0;
      div_en   = 1'b0;
      repeat (3) @(negedge i_ref_clk);
      sb_q.delete();
      cfg_per     = per;
      cfg_alt     = alt;
      i_exp_ratio = exp;
      i_mon_en    = 1'b1;
      repeat (4) @(negedge i_ref_clk);
      div_en = en;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_period"},   32'(o_period),   32'd0);
      chk({tag, "_high"},     32'(o_high),     32'd0);
      chk({tag, "_valid"},    32'(o_valid),    32'd0);
      chk({tag, "_locked"},   32'(o_locked),   32'd0);
      chk({tag, "_mismatch"}, 32'(o_mismatch), 32'd0);
      chk({tag, "_timeout"},  32'(o_timeout),  32'd0);
   endtask

   initial begin
      int vcnt;
      int budget;
      i_rst_n     = 1'b0;
      i_mon_en    = 1'b0;
      i_exp_ratio = 8'd4;
      i_err_clr   = 1'b0;
      repeat (3) @(negedge i_ref_clk);
      chk_all_zero("rst");

      // Run, then reset mid-run.
      i_rst_n  = 1'b1;
      i_mon_en = 1'b1;
      cfg_per  = 4;
      repeat (4) @(negedge i_ref_clk);
      div_en = 1'b1;
      wait_valid(3);
      i_rst_n = 1'b0;
      div_en  = 1'b0;
      #2;
      chk_all_zero("midrst");
      repeat (3) @(negedge i_ref_clk);
      chk_all_zero("midrst_hold");
      sb_q.delete();
      i_rst_n = 1'b1;
      repeat (4) @(negedge i_ref_clk);
      div_en = 1'b1;
      wait_valid(1);
      chk("r4_lock1", 32'(o_locked), 32'd0);
      wait_valid(1);
      chk("r4_lock2", 32'(o_locked), 32'd1);
      chk("r4_mm", 32'(o_mismatch), 32'd0);

      // Odd ratio with alternating 3/2 high times.
      start_run(5, 1'b1, 8'd5, 1'b1);
      wait_valid(4);
      chk("r5_lock", 32'(o_locked), 32'd1);
      chk("r5_mm", 32'(o_mismatch), 32'd0);

      // Minimum checked ratio.
      start_run(2, 1'b0, 8'd2, 1'b1);
      wait_valid(1);
      chk("r2_lock1", 32'(o_locked), 32'd0);
      wait_valid(1);
      chk("r2_lock2", 32'(o_locked), 32'd1);

      // Lock at 6, then the divider moves to 8.
      start_run(6, 1'b0, 8'd6, 1'b1);
      wait_valid(3);
      chk("r6_lock", 32'(o_locked), 32'd1);
      cfg_per = 8;
      for (int i = 0; i < 5; i++) begin
         wait_valid(1);
         if (o_period == 8'd8) break;
      end
      chk("r8_period", 32'(o_period), 32'd8);
      chk("r8_mm", 32'(o_mismatch), 32'd1);
      chk("r8_lock", 32'(o_locked), 32'd0);
      i_err_clr = 1'b1;
      @(posedge i_ref_clk);
      #1;
      i_err_clr = 1'b0;
      chk("errclr_mm", 32'(o_mismatch), 32'd0);

      // Loss of clock after lock: timeout exactly 1023 cycles after the capture.
      start_run(6, 1'b0, 8'd6, 1'b1);
      wait_valid(2);
      chk("to_prelock", 32'(o_locked), 32'd1);
      wait_valid(1);
      div_en = 1'b0;
      repeat (1022) @(posedge i_ref_clk);
      #1;
      chk("to_early", 32'(o_timeout), 32'd0);
      @(posedge i_ref_clk);
      #1;
      chk("to_set", 32'(o_timeout), 32'd1);
      chk("to_lock", 32'(o_locked), 32'd0);
      div_en = 1'b1;
      wait_valid(2);
      chk("to_relock", 32'(o_locked), 32'd1);

      // Bypass ratio with the divided clock stuck low.
      start_run(6, 1'b0, 8'd1, 1'b0);
      budget = 0;
      while (!o_timeout && budget < 1200) begin
         @(posedge i_ref_clk);
         #1;
         budget++;
      end
      chk("byp_to", 32'(o_timeout), 32'd1);
      chk("byp_mm", 32'(o_mismatch), 32'd0);
      chk("byp_lock", 32'(o_locked), 32'd0);
      div_en = 1'b1;
      wait_valid(2);
      chk("byp_run_lock", 32'(o_locked), 32'd0);
      chk("byp_run_mm", 32'(o_mismatch), 32'd0);

      // Disable mid-period: no capture, all results cleared.
      i_mon_en = 1'b0;
      div_en   = 1'b0;
      vcnt     = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge i_ref_clk);
         #1;
         if (o_valid) vcnt++;
      end
      chk("dis_valids", 32'(vcnt), 32'd0);
      chk_all_zero("dis");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
